traffic_phase_scheduler: RTL

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

---
 rtl/traffic_pkg.sv | 17 +
 rtl/phase_timer.sv | 18 +
 rtl/traffic_phase_scheduler.sv | 86 ++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state enumeration and lamp encodings for the traffic phase scheduler
package traffic_pkg;
    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        A_ALLRED = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        B_ALLRED = 3'd5,
        WALK     = 3'd6
    } state_t;
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } lamp_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating dwell counter, zeroed whenever the phase changes
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   clear : next cycle starts a new phase, count returns to 0
//   count : cycles spent in the current phase, sticks at all-ones
module phase_timer #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    output logic [W-1:0] count
);
    always_ff @(posedge clock or negedge reset)
        if (!reset) count <= '0;
        else if (clear) count <= '0;
        else if (count != '1) count <= count + 1'b1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-road signal controller with pedestrian walk phase and road-A preemption
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   ta, tb              : vehicle presence on road A / road B
//   ped_req             : pedestrian button
//   emerg_a             : preemption request favouring road A
//   la, lb              : lamp codes for road A / road B
//   walk                : pedestrian walk lamp
//   ped_pending         : latched pedestrian request
//   phase               : current state code
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 16,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ta,
    input  logic       tb,
    input  logic       ped_req,
    input  logic       emerg_a,
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);
    localparam int TW = $clog2(GREEN_MAX) + 1;
    state_t        r_state;
    state_t        w_next;
    logic          r_ped;
    logic          r_ret;
    logic [TW-1:0] w_t;
    int            w_ti;
    logic          w_gmin;
    logic          w_gmax;
    logic          w_yend;
    logic          w_rend;
    logic          w_wend;
    logic          w_walk_entry;
    phase_timer #(.W(TW)) u_timer (
        .clock(clock),
        .reset(reset),
        .clear(w_next != r_state),
        .count(w_t)
    );
    assign w_ti         = int'(w_t);
    assign w_gmin       = w_ti >= GREEN_MIN - 1;
    assign w_gmax       = w_ti >= GREEN_MAX - 1;
    assign w_yend       = w_ti == YELLOW_T - 1;
    assign w_rend       = w_ti == ALLRED_T - 1;
    assign w_wend       = w_ti == WALK_T - 1;
    assign w_walk_entry = (w_next == WALK) && (r_state != WALK);
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            r_state <= A_GREEN;
            r_ped   <= 1'b0;
            r_ret   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ped   <= ped_req | (r_ped & ~w_walk_entry);
            // r_ret = 1 means road B is owed the next green after the walk
            if (w_walk_entry) r_ret <= (r_state == A_ALLRED);
        end
    always_comb begin
        w_next = r_state;
        case (r_state)
            A_GREEN:  if (w_gmin && (tb || r_ped) && (!ta || w_gmax) && !emerg_a) w_next = A_YELLOW;
            A_YELLOW: if (w_yend) w_next = A_ALLRED;
            A_ALLRED: if (w_rend) w_next = (r_ped && !emerg_a) ? WALK : B_GREEN;
            B_GREEN:  if (emerg_a || (w_gmin && (ta || r_ped) && (!tb || w_gmax))) w_next = B_YELLOW;
            B_YELLOW: if (w_yend) w_next = B_ALLRED;
            B_ALLRED: if (w_rend) w_next = (r_ped && !emerg_a) ? WALK : A_GREEN;
            WALK:     if (emerg_a || w_wend) w_next = (r_ret && !emerg_a) ? B_GREEN : A_GREEN;
            default:  w_next = A_GREEN;
        endcase
        la          = (r_state == A_GREEN) ? GREEN : (r_state == A_YELLOW) ? YELLOW : RED;
        lb          = (r_state == B_GREEN) ? GREEN : (r_state == B_YELLOW) ? YELLOW : RED;
        walk        = r_state == WALK;
        ped_pending = r_ped;
        phase       = r_state;
    end
endmodule
